// File: rtl/mem_fill_engine.sv
// Programmable RAM fill engine: walks base..base+length-1 and drives one SDRAM write
// per two pacing events, with pend-on-ready, abort and a busy/done handshake.
module mem_fill_engine #(
    parameter int ADDR_W  = 23,
    parameter int DATA_W  = 8,
    parameter int CE_EDGE = 1
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              ce,
    input  logic              start,
    input  logic              abort,
    input  logic              mem_ready,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] length,
    input  logic [1:0]        mode,
    input  logic [DATA_W-1:0] fill_pattern,
    output logic              busy,
    output logic              done,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din
);

    typedef enum logic [1:0] {ST_IDLE, ST_PEND, ST_GAP, ST_WR} state_t;

    state_t state_reg, state_next;

    logic              start_q_reg;
    logic              ce_q_reg;
    logic              start_edge;
    logic              ce_evt;
    logic              accept;
    logic              last_word;
    logic              load_params;

    logic [ADDR_W-1:0] base_reg, len_reg, offset_reg, offset_next;
    logic [1:0]        mode_reg;
    logic [DATA_W-1:0] pat_reg;

    logic              busy_reg, busy_next;
    logic              done_reg, done_next;
    logic              we_reg, we_next;
    logic [ADDR_W-1:0] addr_reg, addr_next;
    logic [DATA_W-1:0] din_reg, din_next;

    logic [ADDR_W-1:0] gen_base, gen_off, gen_addr;
    logic [1:0]        gen_mode;
    logic [DATA_W-1:0] gen_pat, gen_din, addr_lo, off_lo;

    // start_q is deliberately outside reset so a start held through reset yields no edge.
    always_ff @(posedge clk_sys) begin
        start_q_reg <= start;
    end

    always_ff @(posedge clk_sys) begin
        if (reset) ce_q_reg <= 1'b0;
        else       ce_q_reg <= ce;
    end

    assign start_edge = start & ~start_q_reg;
    assign ce_evt     = (CE_EDGE != 0) ? (ce & ~ce_q_reg) : ce;
    assign accept     = (state_reg == ST_IDLE) & start_edge & ~abort;
    assign last_word  = (offset_reg == (len_reg - ADDR_W'(1)));

    // Word generator: first word straight from the inputs at acceptance, later words from latched state.
    assign gen_base = accept ? base_addr    : base_reg;
    assign gen_off  = accept ? '0           : offset_reg + ADDR_W'(1);
    assign gen_mode = accept ? mode         : mode_reg;
    assign gen_pat  = accept ? fill_pattern : pat_reg;
    assign gen_addr = gen_base + gen_off;

    generate
        for (genvar gi = 0; gi < DATA_W; gi++) begin : g_lo
            if (gi < ADDR_W) begin : g_in
                assign addr_lo[gi] = gen_addr[gi];
                assign off_lo[gi]  = gen_off[gi];
            end else begin : g_pad
                assign addr_lo[gi] = 1'b0;
                assign off_lo[gi]  = 1'b0;
            end
        end
    endgenerate

    always_comb begin
        gen_din = '0;
        case (gen_mode)
            2'd0:    gen_din = '0;
            2'd1:    gen_din = gen_pat;
            2'd2:    gen_din = gen_pat + off_lo;
            default: gen_din = gen_pat ^ addr_lo;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (reset) state_reg <= ST_IDLE;
        else       state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (accept && (length != '0))
                    state_next = mem_ready ? ST_GAP : ST_PEND;
            end
            ST_PEND: begin
                if (abort)          state_next = ST_IDLE;
                else if (mem_ready) state_next = ST_GAP;
            end
            ST_GAP: begin
                if (abort)       state_next = ST_IDLE;
                else if (ce_evt) state_next = ST_WR;
            end
            ST_WR: begin
                if (abort)       state_next = ST_IDLE;
                else if (ce_evt) state_next = last_word ? ST_IDLE : ST_GAP;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        busy_next   = busy_reg;
        done_next   = 1'b0;
        we_next     = we_reg;
        addr_next   = addr_reg;
        din_next    = din_reg;
        offset_next = offset_reg;
        load_params = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (accept) begin
                    load_params = 1'b1;
                    offset_next = '0;
                    if (length == '0) begin
                        done_next = 1'b1;
                    end else begin
                        busy_next = 1'b1;
                        addr_next = gen_addr;
                        din_next  = gen_din;
                    end
                end
            end
            ST_PEND: begin
                if (abort) busy_next = 1'b0;
            end
            ST_GAP: begin
                if (abort) begin
                    busy_next = 1'b0;
                    we_next   = 1'b0;
                end else if (ce_evt) begin
                    we_next = 1'b1;
                end
            end
            ST_WR: begin
                if (abort) begin
                    busy_next = 1'b0;
                    we_next   = 1'b0;
                end else if (ce_evt) begin
                    we_next = 1'b0;
                    if (last_word) begin
                        busy_next = 1'b0;
                        done_next = 1'b1;
                    end else begin
                        offset_next = offset_reg + ADDR_W'(1);
                        addr_next   = gen_addr;
                        din_next    = gen_din;
                    end
                end
            end
            default: begin
                busy_next = 1'b0;
                we_next   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
            we_reg     <= 1'b0;
            addr_reg   <= '0;
            din_reg    <= '0;
            offset_reg <= '0;
            base_reg   <= '0;
            len_reg    <= '0;
            mode_reg   <= '0;
            pat_reg    <= '0;
        end else begin
            busy_reg   <= busy_next;
            done_reg   <= done_next;
            we_reg     <= we_next;
            addr_reg   <= addr_next;
            din_reg    <= din_next;
            offset_reg <= offset_next;
            if (load_params) begin
                base_reg <= base_addr;
                len_reg  <= length;
                mode_reg <= mode;
                pat_reg  <= fill_pattern;
            end
        end
    end

    assign busy     = busy_reg;
    assign done     = done_reg;
    assign mem_we   = we_reg;
    assign mem_addr = addr_reg;
    assign mem_din  = din_reg;

endmodule
